deserializer_flex: RTL
======================

Name: deserializer_flex

Overview:
Parametrised successor to the team's fixed 16-bit serial-to-parallel deserializer. It collects DATA_W serial bits into a word with per-word MSB/LSB-first ordering and early termination on a last marker (partial word plus bit count). It adds ready/valid backpressure on both sides. It sits between bit-serial link receivers and word-wide stream consumers.

Parameters:
DATA_W, 16, word width in bits; legal values are 2 and above.
CNT_W, $clog2(DATA_W+1), localparam; width of bit counter and length output.

Ports:
clk_i  input  1  clock; all logic on rising edge.
arst_i  input  1  asynchronous reset, active-high.
data_i  input  1  serial data bit.
data_val_i  input  1  data_i valid.
data_last_i  input  1  qualifies the accepted bit as the final bit of the word.
msb_first_i  input  1  1 = first bit goes to MSB, 0 = first bit goes to LSB; sampled on the first accepted bit of each word.
data_ready_o  output  1  block can accept a serial bit; registered.
deser_data_o  output  DATA_W  assembled word; unfilled positions are 0.
deser_data_len_o  output  CNT_W  number of valid bits in the word, from 1 to DATA_W.
deser_data_val_o  output  1  output word valid.
deser_data_ready_i  input  1  downstream accepts the output word.

Behaviour:
- Reset: asynchronous. All outputs and internal state are 0, except data_ready_o, which is 1. A partial word in progress at reset is discarded.
- Accept: a bit is accepted when data_val_i && data_ready_o. data_last_i and msb_first_i are ignored on cycles with no accept.
- Bit placement: bit k of a word (k = 0 is the first bit) goes to position DATA_W-1-k if the latched order is MSB-first, otherwise to position k.
- Latched order: taken from msb_first_i at k = 0 and held for the whole word; changes mid-word have no effect.
- Word completion: the word completes on the accepted bit where k == DATA_W-1, or on any accepted bit with data_last_i = 1.
  - Length = k+1.
  - Assembly register and counter clear for the next word.
  - data_last_i on the DATA_W-th bit is a normal full word (len = DATA_W).
- FSM states:
  - COLLECT: data_ready_o = 1. On completion, if the output stage is free or being drained this cycle (deser_data_val_o && deser_data_ready_i), transfer the word to the output and stay in COLLECT. Otherwise go to HOLD.
  - HOLD: data_ready_o = 0; the completed word is held in the assembly register. On the first cycle the output stage is free or drains, transfer the word and return to COLLECT.
- Output stage:
  - Latency: deser_data_val_o rises on the cycle after the completing bit's accept edge when the stage is free.
  - While deser_data_val_o = 1 and deser_data_ready_i = 0, deser_data_o, deser_data_len_o and deser_data_val_o are held stable.
  - deser_data_val_o falls after a handshake unless a new word is loaded on the same edge.
- Throughput: back-to-back full words with deser_data_ready_i tied to 1 run at 1 bit/clock with no bubbles.
- No combinational path from any input to any output.

Optional Feature:
Macro DESERIALIZER_FLEX_PARITY_EN.
- Defined:
  - After each word completes, the FSM enters state PARITY; data_ready_o stays 1.
  - The next accepted bit is an even-parity bit over the word's valid bits (XOR of data bits and parity bit must equal 0); data_last_i is ignored on this bit.
  - Word and result transfer together to the output stage. Output port deser_parity_err_o (1 bit, reset 0) is 1 on mismatch, qualified by deser_data_val_o.
  - Completion, HOLD entry and latency counts are taken from the parity bit's accept.
- Undefined: no PARITY state, no parity bit, and the deser_parity_err_o port is absent.

Decomposition:
- Package deserializer_flex_pkg: FSM state enum typedef (COLLECT, HOLD, PARITY), order-encoding constants (ORDER_MSB = 1'b1, ORDER_LSB = 1'b0).
- Sub-module deser_out_stage: the one-entry output holding register with valid/ready, parametrised by DATA_W and CNT_W. It is reused by the other wide-stream blocks.

Test Plan:
- Full MSB-first, DATA_W=16: 16 bits 1010_0000_0000_0011, deser_data_ready_i=1 -> one cycle after the 16th accept, deser_data_o=16'hA003, len=16, val pulse 1 cycle.
- LSB-first: same bit sequence with msb_first_i=0 -> deser_data_o=16'hC005; flip msb_first_i mid-word -> no effect.
- Partial word: 5 bits 1,1,0,1,1 with data_last_i on the 5th, MSB-first -> deser_data_o=16'hD800, len=5. Next word starts at k=0.
- Backpressure: deser_data_ready_i=0 through two full words -> first word held stable; data_ready_o drops the cycle after the second word completes. Releasing ready drains both words in order with no bit lost.
- Async reset mid-word after 7 bits -> outputs 0 and data_ready_o=1 immediately without clock. The next 16 bits form a clean word.
- Parity build: word 16'h0001 with parity bit 1 -> deser_parity_err_o=0; with parity bit 0 -> deser_parity_err_o=1.

Source files
------------

// File: rtl/deserializer_flex_pkg.sv
// Shared types for the flexible deserializer: FSM states and bit-order encoding.
package deserializer_flex_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        PARITY  = 2'd2
    } deser_state_e;

    localparam logic ORDER_MSB = 1'b1;
    localparam logic ORDER_LSB = 1'b0;

endpackage

// File: rtl/deser_out_stage.sv
// One-entry output holding register with valid/ready handshake.
// The producer may only pulse load_i while free_o is high.
module deser_out_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              ready_i,
    output logic              free_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  len_o,
    output logic              val_o
);

    logic              r_val;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_len;

    // Free when empty, or when the current word leaves on this edge.
    assign free_o = !r_val || ready_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_val  <= 1'b0;
            r_data <= '0;
            r_len  <= '0;
        end else if (load_i) begin
            r_val  <= 1'b1;
            r_data <= data_i;
            r_len  <= len_i;
        end else if (ready_i) begin
            r_val  <= 1'b0;
        end
    end

    assign data_o = r_data;
    assign len_o  = r_len;
    assign val_o  = r_val;

endmodule

// File: rtl/deserializer_flex.sv
// Serial-to-parallel deserializer with per-word bit order, early termination
// and ready/valid on both sides. Optional parity: DESERIALIZER_FLEX_PARITY_EN.
module deserializer_flex
    import deserializer_flex_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    input  logic              data_last_i,
    input  logic              msb_first_i,
    output logic              data_ready_o,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [CNT_W-1:0]  deser_data_len_o,
    output logic              deser_data_val_o,
    input  logic              deser_data_ready_i
`ifdef DESERIALIZER_FLEX_PARITY_EN
    ,
    output logic              deser_parity_err_o
`endif
);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA_W - 1);

    deser_state_e      r_state;
    logic              r_ready;
    logic [DATA_W-1:0] r_asm;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_len;
    logic              r_order;
`ifdef DESERIALIZER_FLEX_PARITY_EN
    logic              r_par;
    logic              r_perr;
    logic              r_err_out;
    logic              w_load_err;
`endif

    logic              w_accept;
    logic              w_order;
    logic [CNT_W-1:0]  w_pos;
    logic [DATA_W-1:0] w_asm_set;
    logic              w_done;
    logic [CNT_W-1:0]  w_len_now;
    logic              w_stage_free;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic [CNT_W-1:0]  w_load_len;

    assign w_accept  = data_val_i && r_ready;
    // The order input only matters on the first bit of a word.
    assign w_order   = (r_cnt == '0) ? msb_first_i : r_order;
    assign w_pos     = (w_order == ORDER_MSB) ? (LAST_POS - r_cnt) : r_cnt;
    assign w_done    = (r_cnt == LAST_POS) || data_last_i;
    assign w_len_now = r_cnt + CNT_W'(1);

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_place
        assign w_asm_set[gi] = (w_pos == CNT_W'(gi)) ? data_i : r_asm[gi];
    end

    always_comb begin
        w_load      = 1'b0;
        w_load_data = w_asm_set;
        w_load_len  = w_len_now;
`ifdef DESERIALIZER_FLEX_PARITY_EN
        w_load_err  = 1'b0;
`endif
        case (r_state)
`ifndef DESERIALIZER_FLEX_PARITY_EN
            COLLECT: w_load = w_accept && w_done && w_stage_free;
`else
            PARITY: begin
                w_load      = w_accept && w_stage_free;
                w_load_data = r_asm;
                w_load_len  = r_len;
                w_load_err  = r_par ^ data_i;
            end
`endif
            HOLD: begin
                w_load      = w_stage_free;
                w_load_data = r_asm;
                w_load_len  = r_len;
`ifdef DESERIALIZER_FLEX_PARITY_EN
                w_load_err  = r_perr;
`endif
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= COLLECT;
            r_ready <= 1'b1;
            r_asm   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_order <= ORDER_LSB;
`ifdef DESERIALIZER_FLEX_PARITY_EN
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
            r_err_out <= 1'b0;
`endif
        end else begin
`ifdef DESERIALIZER_FLEX_PARITY_EN
            if (w_load) r_err_out <= w_load_err;
`endif
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_order <= w_order;
`ifdef DESERIALIZER_FLEX_PARITY_EN
                        r_par   <= r_par ^ data_i;
`endif
                        if (w_done) begin
                            r_cnt <= '0;
`ifdef DESERIALIZER_FLEX_PARITY_EN
                            r_asm   <= w_asm_set;
                            r_len   <= w_len_now;
                            r_state <= PARITY;
`else
                            if (w_stage_free) begin
                                r_asm <= '0;
                            end else begin
                                r_asm   <= w_asm_set;
                                r_len   <= w_len_now;
                                r_state <= HOLD;
                                r_ready <= 1'b0;
                            end
`endif
                        end else begin
                            r_asm <= w_asm_set;
                            r_cnt <= w_len_now;
                        end
                    end
                end
`ifdef DESERIALIZER_FLEX_PARITY_EN
                PARITY: begin
                    if (w_accept) begin
                        if (w_stage_free) begin
                            r_asm   <= '0;
                            r_par   <= 1'b0;
                            r_state <= COLLECT;
                        end else begin
                            r_perr  <= r_par ^ data_i;
                            r_state <= HOLD;
                            r_ready <= 1'b0;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (w_stage_free) begin
                        r_asm   <= '0;
`ifdef DESERIALIZER_FLEX_PARITY_EN
                        r_par   <= 1'b0;
`endif
                        r_state <= COLLECT;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    deser_out_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_out_stage (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .load_i  (w_load),
        .data_i  (w_load_data),
        .len_i   (w_load_len),
        .ready_i (deser_data_ready_i),
        .free_o  (w_stage_free),
        .data_o  (deser_data_o),
        .len_o   (deser_data_len_o),
        .val_o   (deser_data_val_o)
    );

    assign data_ready_o = r_ready;
`ifdef DESERIALIZER_FLEX_PARITY_EN
    assign deser_parity_err_o = r_err_out;
`endif

endmodule
